// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order two-lane issue stage for RV32I. It looks at the two oldest
//   buffered instructions, blocks lane0 on a busy source register (freeze1)
//   or on a busy data memory port (freeze2), and pairs instruction1 into
//   lane1 only when the two are independent. Busy state lives in a per-register
//   2-bit countdown scoreboard, armed by issued loads.
//
// Ports
//   clk, n_rst              clock (rising edge), asynchronous active-low reset
//   nothing_filled          fetch buffer empty
//   instruction0/1          oldest / next buffered instruction (0 = empty slot)
//   mem_busy                data memory port cannot take a request this cycle
//   freeze1                 lane0 held on scoreboard hazard
//   freeze2                 lane0 held on mem_busy
//   dependency_on_ins2      only instruction0 issues, buffer slides by one
//   issue0_valid/_instr     registered lane0 issue
//   issue1_valid/_instr     registered lane1 issue
//   issued_count            running count of issued instructions
//   stall_count             running count of freeze1|freeze2 cycles
module dual_issue_scheduler #(
  parameter int LOAD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        nothing_filled,
  input  logic [31:0] instruction0,
  input  logic [31:0] instruction1,
  input  logic        mem_busy,
  output logic        freeze1,
  output logic        freeze2,
  output logic        dependency_on_ins2,
  output logic        issue0_valid,
  output logic [31:0] issue0_instr,
  output logic        issue1_valid,
  output logic [31:0] issue1_instr,
  output logic [31:0] issued_count,
  output logic [31:0] stall_count
);

  localparam logic [1:0] LAT = 2'(LOAD_LATENCY);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return !(op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);
  endfunction

  logic [1:0]  sb [31:1];
  logic [31:0] busy;

  logic [6:0] op0, op1;
  logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic       src1_0, src2_0, dst0, src1_1, src2_1, dst1;
  logic       lane0_full, issue0, issue1, raw, waw, busy1;

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (sb[r] != 2'd0);
  end

  assign op0   = instruction0[6:0];
  assign rd0   = instruction0[11:7];
  assign rs1_0 = instruction0[19:15];
  assign rs2_0 = instruction0[24:20];
  assign op1   = instruction1[6:0];
  assign rd1   = instruction1[11:7];
  assign rs1_1 = instruction1[19:15];
  assign rs2_1 = instruction1[24:20];

  // Effective register references; x0 never takes part in a hazard.
  assign src1_0 = uses_rs1(op0) && (rs1_0 != 5'd0);
  assign src2_0 = uses_rs2(op0) && (rs2_0 != 5'd0);
  assign dst0   = writes_rd(op0) && (rd0 != 5'd0);
  assign src1_1 = uses_rs1(op1) && (rs1_1 != 5'd0);
  assign src2_1 = uses_rs2(op1) && (rs2_1 != 5'd0);
  assign dst1   = writes_rd(op1) && (rd1 != 5'd0);

  assign raw   = dst0 && ((src1_1 && rs1_1 == rd0) || (src2_1 && rs2_1 == rd0));
  assign waw   = dst0 && dst1 && (rd0 == rd1);
  assign busy1 = (src1_1 && busy[rs1_1]) || (src2_1 && busy[rs2_1]);

  assign lane0_full = !nothing_filled && (instruction0 != 32'd0);
  assign freeze1    = lane0_full && ((src1_0 && busy[rs1_0]) || (src2_0 && busy[rs2_0]));
  assign freeze2    = lane0_full && !freeze1 && is_mem(op0) && mem_busy;
  assign issue0     = lane0_full && !freeze1 && !freeze2;

  assign dependency_on_ins2 = issue0 && ((instruction1 == 32'd0) || raw || waw ||
                              (is_mem(op0) && is_mem(op1)) || is_ctrl(op0) || busy1 ||
                              (is_mem(op1) && mem_busy));
  assign issue1 = issue0 && !dependency_on_ins2;

  // Decision cycle -> scoreboard update (load arms, others count down)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 1; r < 32; r++) sb[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if ((issue0 && op0 == OP_LOAD && rd0 == r[4:0]) ||
            (issue1 && op1 == OP_LOAD && rd1 == r[4:0]))
          sb[r] <= LAT;
        else if (sb[r] != 2'd0)
          sb[r] <= sb[r] - 2'd1;
      end
    end
  end

  // Decision cycle -> registered issue outputs and statistics (_p1)
  logic        issue0_vld_p1, issue1_vld_p1;
  logic [31:0] issue0_instr_p1, issue1_instr_p1;
  logic [31:0] issued_cnt_p1, stall_cnt_p1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      issue0_vld_p1   <= 1'b0;
      issue1_vld_p1   <= 1'b0;
      issue0_instr_p1 <= '0;
      issue1_instr_p1 <= '0;
      issued_cnt_p1   <= '0;
      stall_cnt_p1    <= '0;
    end else begin
      issue0_vld_p1   <= issue0;
      issue1_vld_p1   <= issue1;
      issue0_instr_p1 <= issue0 ? instruction0 : 32'd0;
      issue1_instr_p1 <= issue1 ? instruction1 : 32'd0;
      issued_cnt_p1   <= issued_cnt_p1 + {31'd0, issue0} + {31'd0, issue1};
      stall_cnt_p1    <= stall_cnt_p1 + {31'd0, (freeze1 | freeze2)};
    end
  end

  assign issue0_valid = issue0_vld_p1;
  assign issue1_valid = issue1_vld_p1;
  assign issue0_instr = issue0_instr_p1;
  assign issue1_instr = issue1_instr_p1;
  assign issued_count = issued_cnt_p1;
  assign stall_count  = stall_cnt_p1;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

  localparam logic [31:0] ADDI1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] ADDIX = 32'h00108113;  // addi x2,x1,1
  localparam logic [31:0] LW5   = 32'h00002283;  // lw x5,0(x0)
  localparam logic [31:0] SW1   = 32'h00102023;  // sw x1,0(x0)
  localparam logic [31:0] ADD6  = 32'h00528333;  // add x6,x5,x5
  localparam logic [31:0] BEQ   = 32'h00000063;  // beq x0,x0,0

  logic        clk = 1'b0;
  logic        n_rst;
  logic        nothing_filled;
  logic [31:0] instruction0, instruction1;
  logic        mem_busy;
  logic        freeze1, freeze2, dependency_on_ins2;
  logic        issue0_valid, issue1_valid;
  logic [31:0] issue0_instr, issue1_instr, issued_count, stall_count;

  int checks = 0;
  int errors = 0;

  dual_issue_scheduler #(.LOAD_LATENCY(2)) dut (
    .clk(clk), .n_rst(n_rst), .nothing_filled(nothing_filled),
    .instruction0(instruction0), .instruction1(instruction1), .mem_busy(mem_busy),
    .freeze1(freeze1), .freeze2(freeze2), .dependency_on_ins2(dependency_on_ins2),
    .issue0_valid(issue0_valid), .issue0_instr(issue0_instr),
    .issue1_valid(issue1_valid), .issue1_instr(issue1_instr),
    .issued_count(issued_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic f1, input logic f2, input logic dep);
    chk({tag, ".freeze1"}, {31'd0, freeze1}, {31'd0, f1});
    chk({tag, ".freeze2"}, {31'd0, freeze2}, {31'd0, f2});
    chk({tag, ".dep"}, {31'd0, dependency_on_ins2}, {31'd0, dep});
  endtask

  initial begin
    n_rst = 1'b0; nothing_filled = 1'b1; instruction0 = '0; instruction1 = '0; mem_busy = 1'b0;
    cyc(); cyc();
    chk("rst.v0", {31'd0, issue0_valid}, 32'd0);
    chk("rst.v1", {31'd0, issue1_valid}, 32'd0);
    chk("rst.issued", issued_count, 32'd0);
    chk("rst.stall", stall_count, 32'd0);
    n_rst = 1'b1;

    // Empty buffer: nothing happens even with an instruction present
    instruction0 = ADDI1; #1;
    flags("empty", 1'b0, 1'b0, 1'b0);
    cyc();
    chk("empty.v0", {31'd0, issue0_valid}, 32'd0);
    chk("empty.issued", issued_count, 32'd0);

    // Independent pair issues in both lanes
    nothing_filled = 1'b0; instruction0 = ADDI1; instruction1 = ADDI2; #1;
    flags("pair", 1'b0, 1'b0, 1'b0);
    cyc();
    chk("pair.v0", {31'd0, issue0_valid}, 32'd1);
    chk("pair.v1", {31'd0, issue1_valid}, 32'd1);
    chk("pair.i0", issue0_instr, ADDI1);
    chk("pair.i1", issue1_instr, ADDI2);
    chk("pair.issued", issued_count, 32'd2);

    // RAW between lanes
    instruction1 = ADDIX; #1;
    flags("raw", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("raw.v0", {31'd0, issue0_valid}, 32'd1);
    chk("raw.v1", {31'd0, issue1_valid}, 32'd0);
    chk("raw.i1", issue1_instr, 32'd0);
    chk("raw.issued", issued_count, 32'd3);

    // Two memory ops cannot pair; the lw issues alone and arms x5
    instruction0 = LW5; instruction1 = SW1; #1;
    flags("mem2", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("mem2.i0", issue0_instr, LW5);
    chk("mem2.issued", issued_count, 32'd4);

    // Load-use: add stalls two cycles then issues
    instruction0 = ADD6; instruction1 = '0; #1;
    flags("use.c1", 1'b1, 1'b0, 1'b0);
    cyc();
    chk("use.c1.v0", {31'd0, issue0_valid}, 32'd0);
    chk("use.c1.stall", stall_count, 32'd1);
    flags("use.c2", 1'b1, 1'b0, 1'b0);
    cyc();
    chk("use.c2.stall", stall_count, 32'd2);
    flags("use.c3", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("use.c3.v0", {31'd0, issue0_valid}, 32'd1);
    chk("use.c3.i0", issue0_instr, ADD6);
    chk("use.issued", issued_count, 32'd5);
    chk("use.stall", stall_count, 32'd2);

    // mem_busy holds the load; scoreboard stays clear
    instruction0 = LW5; mem_busy = 1'b1; #1;
    flags("mbusy", 1'b0, 1'b1, 1'b0);
    cyc();
    chk("mbusy.v0", {31'd0, issue0_valid}, 32'd0);
    chk("mbusy.stall", stall_count, 32'd3);
    instruction0 = ADD6; mem_busy = 1'b0; #1;
    flags("mbusy.noarm", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("mbusy.noarm.i0", issue0_instr, ADD6);
    instruction0 = LW5; #1;
    flags("mfree", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("mfree.i0", issue0_instr, LW5);
    chk("mfree.issued", issued_count, 32'd7);

    // Control op in lane0 never pairs (x5 still busy but beq reads only x0)
    instruction0 = BEQ; instruction1 = ADDI1; #1;
    flags("ctrl", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ctrl.v1", {31'd0, issue1_valid}, 32'd0);
    chk("ctrl.issued", issued_count, 32'd8);

    // Lane1 memory op blocked by mem_busy, then lane1 load arms x5
    instruction0 = ADDI1; instruction1 = LW5; mem_busy = 1'b1; #1;
    flags("l1busy", 1'b0, 1'b0, 1'b1);
    cyc();
    mem_busy = 1'b0; #1;
    flags("l1load", 1'b0, 1'b0, 1'b0);
    cyc();
    chk("l1load.i1", issue1_instr, LW5);
    chk("l1load.issued", issued_count, 32'd11);
    instruction0 = ADD6; instruction1 = '0; #1;
    flags("l1use", 1'b1, 1'b0, 1'b0);

    // Reset mid-stall clears busy state and statistics
    cyc();
    n_rst = 1'b0; #1;
    chk("arst.v0", {31'd0, issue0_valid}, 32'd0);
    chk("arst.issued", issued_count, 32'd0);
    chk("arst.stall", stall_count, 32'd0);
    chk("arst.f1", {31'd0, freeze1}, 32'd0);
    cyc();
    #3 n_rst = 1'b1; #1;
    flags("post", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("post.i0", issue0_instr, ADD6);
    chk("post.issued", issued_count, 32'd1);
    chk("post.stall", stall_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 SHALL have parameter LOAD_LATENCY, default 2, legal 1..3: cycles a load destination stays busy.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port nothing_filled  input  1  fetch buffer empty.
REQ-005 SHALL have port instruction0  input  32  oldest buffered RV32I instruction.
REQ-006 SHALL have port instruction1  input  32  next buffered instruction; 0 = empty.
REQ-007 SHALL have port mem_busy  input  1  data memory port cannot accept a request this cycle.
REQ-008 SHALL have port freeze1  output  1  lane0 stalled on scoreboard; buffer must not slide.
REQ-009 SHALL have port freeze2  output  1  lane0 stalled on mem_busy; buffer must not slide.
REQ-010 SHALL have port dependency_on_ins2  output  1  only instruction0 issues; buffer slides by 1.
REQ-011 SHALL have port issue0_valid / issue0_instr  output  1 / 32  registered lane0 issue.
REQ-012 SHALL have port issue1_valid / issue1_instr  output  1 / 32  registered lane1 issue.
REQ-013 SHALL have port issued_count  output  32  instructions issued, wraps modulo 2^32.
REQ-014 SHALL have port stall_count  output  32  cycles with freeze1|freeze2, wraps modulo 2^32.

Function
REQ-015 Decode SHALL use opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20]; rs1 used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111; rs2 used only for 0110011, 0100011, 1100011; rd written unless opcode is 0100011 or 1100011; x0 never a source or destination of a hazard.
REQ-016 Memory op = opcode 0000011 (load) or 0100011 (store); control op = 1100011, 1101111 or 1100111.
REQ-017 Scoreboard SHALL hold a 2-bit counter per register x1..x31; a register is busy while its counter is nonzero.
REQ-018 Issuing a load with rd != 0 in either lane SHALL set counter[rd] to LOAD_LATENCY at that edge; every other nonzero counter SHALL decrement by 1 per cycle; set wins over decrement on the same register.
REQ-019 Lane0 empty (nothing_filled=1 or instruction0=0): no issue, freeze1=freeze2=dependency_on_ins2=0.
REQ-020 freeze1 SHALL be 1, combinationally, when lane0 is non-empty and any used source of instruction0 is busy.
REQ-021 freeze2 SHALL be 1 when lane0 is non-empty, freeze1=0, instruction0 is a memory op and mem_busy=1.
REQ-022 Lane0 issues when non-empty and freeze1=freeze2=0.
REQ-023 dependency_on_ins2 SHALL be 1 when lane0 issues and any of: instruction1=0; a used source of instruction1 equals a nonzero rd of instruction0 (RAW); both rd equal and nonzero (WAW); both are memory ops; instruction0 is a control op; a used source of instruction1 is busy; instruction1 is a memory op and mem_busy=1.
REQ-024 Lane1 issues when lane0 issues and dependency_on_ins2=0; lane1 never issues without lane0.
REQ-025 freeze1, freeze2, dependency_on_ins2 SHALL be mutually exclusive.
REQ-026 issueN_valid/issueN_instr SHALL register the issue decision one cycle after the decision cycle; non-issuing lane drives valid=0, instr=0.
REQ-027 issued_count SHALL add 0, 1 or 2 per cycle matching lanes issued; stall_count SHALL add 1 per cycle with freeze1|freeze2.

Reset
REQ-028 n_rst=0 SHALL asynchronously clear all scoreboard counters, issue registers and both statistic counters to 0; combinational outputs then follow REQ-019..023 with an empty scoreboard.
REQ-029 Reset asserted mid-stall SHALL discard all pending busy state; first cycle after release sees no busy registers.

Verification
REQ-030 ins0=0x00100093 (addi x1,x0,1), ins1=0x00200113 (addi x2,x0,2) -> freeze1=freeze2=dep=0; next cycle issue0_valid=issue1_valid=1, issued_count +2.
REQ-031 ins0=0x00100093, ins1=0x00108113 (addi x2,x1,1) -> dependency_on_ins2=1; next cycle issue0_valid=1, issue1_valid=0.
REQ-032 Issue 0x00002283 (lw x5) alone, then ins0=0x00528333 (add x6,x5,x5) -> with LOAD_LATENCY=2, freeze1=1 for the 2 cycles after the lw issue cycle, add issues on the third; stall_count +2.
REQ-033 ins0=0x00002283, ins1=0x00102023 (sw x1) -> dependency_on_ins2=1 (single memory port).
REQ-034 ins0=0x00002283, mem_busy=1 -> freeze2=1, freeze1=0, no issue, no scoreboard update; mem_busy=0 next cycle -> lw issues.
REQ-035 ins0=0x00000063 (beq), ins1=0x00100093 -> dependency_on_ins2=1; then n_rst pulse during a REQ-032 stall -> freeze1=0 immediately after release, all counts 0.
